// File: rtl/rsa_modexp_param.sv
// Parametrised modular exponentiation: base^exp mod modulus
// using interleaved shift-add modmul with concurrent square/multiply units.
module rsa_modexp_param #(
  parameter int NBITS = 32,
  parameter int CW    = $clog2(NBITS+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3*NBITS-1:0] istream_msg,
  input  logic               istream_val,
  output logic               istream_rdy,
  output logic [NBITS-1:0]   ostream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    EXP,
    DONE
  } state_e;

  localparam logic [CW-1:0]    CNT_TOP = CW'(NBITS-1);
  localparam logic [NBITS-1:0] ONE     = NBITS'(1);

  state_e           state_q, state_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0] e_q, e_d;
  logic [NBITS-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [NBITS-1:0] bsq_q, bsq_d;
  logic [NBITS-1:0] res_q, res_d;
  logic [NBITS-1:0] q_q, q_d;
  logic [NBITS-1:0] r_q, r_d;

  logic [NBITS:0]   m_x;
  logic [NBITS-1:0] sel;
  logic             b_bit, q_bit, r_bit;
  logic [NBITS:0]   acc_n, q_n, r_n;
  logic [NBITS-1:0] e_sh;
  logic             unused_msb;

  // One modmul step: r' = 2r (+a if bit), each stage reduced below m
  function automatic logic [NBITS:0] mm_step(
    input logic [NBITS:0] r,
    input logic [NBITS:0] a,
    input logic [NBITS:0] m,
    input logic           bt
  );
    logic [NBITS:0] t;
    t = r << 1;
    if (t >= m) t = t - m;
    if (bt) begin
      t = t + a;
      if (t >= m) t = t - m;
    end
    return t;
  endfunction

  // Shared datapath: bit selects and the three step results
  always_comb begin
    m_x   = {1'b0, m_q};
    sel   = ONE << cnt_q;
    b_bit = |(b_q & sel);
    q_bit = |(bsq_q & sel);
    r_bit = |(res_q & sel);
    acc_n = {acc_q, b_bit};
    if (acc_n >= m_x) acc_n = acc_n - m_x;
    q_n   = mm_step({1'b0, q_q}, {1'b0, bsq_q}, m_x, q_bit);
    r_n   = mm_step({1'b0, r_q}, {1'b0, bsq_q}, m_x, r_bit);
    e_sh  = e_q >> 1;
  end

  assign unused_msb = ^{acc_n[NBITS], q_n[NBITS], r_n[NBITS]};

  // Next-state and register update logic
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    e_d     = e_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bsq_d   = bsq_q;
    res_d   = res_q;
    q_d     = q_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE: begin
        if (istream_val) begin
          b_d = istream_msg[3*NBITS-1:2*NBITS];
          e_d = istream_msg[2*NBITS-1:NBITS];
          m_d = istream_msg[NBITS-1:0];
          if (istream_msg[NBITS-1:0] == '0) begin
            res_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_TOP;
            acc_d   = '0;
            state_d = INIT;
          end
        end
      end
      INIT: begin
        acc_d = acc_n[NBITS-1:0];
        if (cnt_q == '0) begin
          bsq_d = acc_n[NBITS-1:0];
          res_d = (m_q == ONE) ? '0 : ONE;
          if (e_q != '0) begin
            cnt_d   = CNT_TOP;
            q_d     = '0;
            r_d     = '0;
            state_d = EXP;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EXP: begin
        q_d = q_n[NBITS-1:0];
        r_d = r_n[NBITS-1:0];
        if (cnt_q == '0) begin
          bsq_d = q_n[NBITS-1:0];
          if (e_q[0]) res_d = r_n[NBITS-1:0];
          e_d   = e_sh;
          cnt_d = CNT_TOP;
          q_d   = '0;
          r_d   = '0;
          if (e_sh == '0) state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (ostream_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      bsq_q   <= '0;
      res_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      e_q     <= e_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bsq_q   <= bsq_d;
      res_q   <= res_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  assign istream_rdy = (state_q == IDLE);
  assign ostream_val = (state_q == DONE);
  assign ostream_msg = res_q;

endmodule

// File: doc/rsa_modexp_param.md
Name: rsa_modexp_param

Overview:
- Parametrised successor to the fixed 32-bit naive modexp unit used behind the RSA accelerator adapter.
- Computes base^exp mod modulus for any operand width NBITS.
- Uses interleaved shift-add modular multiplication (no divider). The squaring and multiply datapaths run concurrently. Iteration stops as soon as the remaining exponent is zero.
- Sits between the xcel adapter (istream) and the response path (ostream) with val/rdy streams.

Parameters:
- NBITS, 32, operand/result width in bits; must be >= 2.
- CW, $clog2(NBITS+1), width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- istream_msg  input  3*NBITS  {base[3N-1:2N], exp[2N-1:N], modulus[N-1:0]}
- istream_val  input  1  request valid
- istream_rdy  output  1  ready to accept a request
- ostream_msg  output  NBITS  result
- ostream_val  output  1  result valid
- ostream_rdy  input  1  consumer ready

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; all registers cleared; istream_rdy=1; ostream_val=0; ostream_msg=0.
- Reset mid-operation: the in-flight request is discarded and no response is produced.
- Handshake: a transfer fires when val&&rdy in the same cycle.
  - istream_rdy=1 only in IDLE.
  - ostream_val=1 only in DONE.
  - ostream_msg is stable while ostream_val=1 and ostream_rdy=0.
  - No new request is accepted in the cycle DONE fires; IDLE is entered next cycle.
- States: IDLE, INIT, EXP, DONE.
- IDLE, on fire:
  - latch base b, exp e, modulus m.
  - if m==0: go to DONE with res=0 (error convention, 1-cycle latency).
  - otherwise go to INIT with cnt=NBITS-1 and acc=0.
- INIT (NBITS cycles): reduce the base, scanning base bits MSB first.
  - Each cycle: acc' = 2*acc + b[cnt]; if acc' >= m then acc' -= m.
  - On the last cycle: bsq = acc' (base mod m); res = (m==1) ? 0 : 1.
  - Then go to EXP if e!=0, else DONE.
- EXP iteration (NBITS cycles each): two interleaved modmul units scan the multiplier bits MSB first.
  - Unit Q computes bsq*bsq mod m.
  - Unit R computes res*bsq mod m, but only if e[0]==1.
  - Per cycle, per unit: t=2*r, if t>=m then t-=m; if bit then t=t+a, if t>=m then t-=m.
  - Datapath is NBITS+1 bits wide; all intermediates stay < 2m.
  - End of iteration: bsq<=Q; if e[0] then res<=R; e<=e>>1.
  - If the new e==0, go to DONE; else start the next iteration.
- DONE: ostream_msg=res, ostream_val=1. On ostream fire go to IDLE.
- Latency: let L = index of the highest set bit of exp, plus 1 (L=0 for exp==0).
  - Handshake in cycle T gives ostream_val first high in cycle T+1+NBITS*(1+L).
  - m==0 gives ostream_val at T+1.
- Boundaries:
  - base >= m is legal (reduced in INIT).
  - base==0 gives 0 for exp>0 and 1 for exp==0 (with m>1).
  - m==1 always gives 0.
  - exp with the MSB set gives L=NBITS.
  - All arithmetic is unsigned.
- Under ostream backpressure the block holds in DONE indefinitely.

Test Plan:
- NBITS=32; base=4, exp=13, m=497, ostream_rdy=1 -> ostream_msg=445; ostream_val at T+161.
- NBITS=32; base=7, exp=0, m=7 -> msg=1 at T+33. Then base=5, exp=3, m=1 -> msg=0 at T+1+32*3=T+97.
- NBITS=32; m=0 with any base/exp -> msg=0 at T+1; istream_rdy low during T+1, high again after the ostream fire.
- NBITS=32; base=0xFFFFFFFF, exp=0x80000001, m=0xFFFFFFFB -> msg matches the reference model; latency T+1+32*33. Hold ostream_rdy=0 for 5 cycles -> msg/val stable, istream_rdy=0 throughout.
- NBITS=64; base=2, exp=10, m=1000 -> msg=24 at T+1+64*5. Back-to-back random requests with random val/rdy stalls, checked against a golden model.
- Drive reset=0 asynchronously mid-EXP (between clk edges) -> val=0 and rdy=1 immediately. After release, a new request (3^5 mod 7) returns 5 with correct latency and no stale response.
